// File: rtl/decoder_nbit_seq.sv
// decoder_nbit_seq: registered binary-to-one-hot decoder with a valid/ready
// select input and an optional auto-scan mode enabled by DECODER_SCAN_EN.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                block enable; low forces outputs idle
//   mode              0 = DIRECT decode, 1 = SCAN (scan build only)
//   in_valid/in_ready select word handshake
//   in                binary select
//   dwell             SCAN: extra cycles each position is held
//   out               registered one-hot (or all-zero) output
//   out_valid         out carries a fresh/valid pattern
//   scan_wrap         1-cycle pulse when the scan returns to bit 0
//
// Build option: define DECODER_SCAN_EN to include the SCAN state, the
// idx/dwell counters and scan_wrap. Without it, mode and dwell are ignored.
module decoder_nbit_seq #(
    parameter int IN_W    = 3,
    parameter int DWELL_W = 8,
    localparam int OUT_W  = 1 << IN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic               scan_wrap
);

`ifdef DECODER_SCAN_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE   = 1'b0,
        DIRECT = 1'b1
    } state_t;
`endif

    state_t           state, state_n;
    logic [OUT_W-1:0] out_q, out_n;
    logic             ov_q, ov_n;
    // Low only until the first clock after reset, so in_ready stays
    // deasserted while the block is held in reset.
    logic             armed;
    logic             scan_req;
    logic             in_scan;
    logic             accept;

`ifdef DECODER_SCAN_EN
    logic [IN_W-1:0]    idx, idx_n;
    logic [IN_W-1:0]    idx_inc;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic               wrap_q, wrap_n;

    assign scan_req = mode;
    assign in_scan  = (state == SCAN);
    assign idx_inc  = idx + 1'b1;
`else
    logic unused_inputs;

    assign scan_req      = 1'b0;
    assign in_scan       = 1'b0;
    assign unused_inputs = ^{mode, dwell};
`endif

    assign in_ready = armed & en & ~scan_req & ~in_scan;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_n = state;
        out_n   = out_q;
        ov_n    = 1'b0;
`ifdef DECODER_SCAN_EN
        idx_n   = idx;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
`endif
        if (!en) begin
            state_n = IDLE;
            out_n   = '0;
`ifdef DECODER_SCAN_EN
            idx_n   = '0;
            cnt_n   = '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (scan_req) begin
`ifdef DECODER_SCAN_EN
                        state_n = SCAN;
                        out_n   = OUT_W'(1);
                        ov_n    = 1'b1;
                        idx_n   = '0;
                        cnt_n   = dwell;
`endif
                    end else begin
                        state_n = DIRECT;
                        if (accept) begin
                            out_n = OUT_W'(1) << in;
                            ov_n  = 1'b1;
                        end
                    end
                end
                DIRECT: begin
                    // A mode change leaves via IDLE for one blank cycle.
                    if (scan_req) begin
                        state_n = IDLE;
                        out_n   = '0;
                    end else if (accept) begin
                        out_n = OUT_W'(1) << in;
                        ov_n  = 1'b1;
                    end
                end
`ifdef DECODER_SCAN_EN
                SCAN: begin
                    if (!scan_req) begin
                        state_n = IDLE;
                        out_n   = '0;
                        idx_n   = '0;
                        cnt_n   = '0;
                    end else begin
                        ov_n = 1'b1;
                        if (cnt == '0) begin
                            // dwell is re-sampled as each position starts.
                            idx_n  = idx_inc;
                            cnt_n  = dwell;
                            out_n  = OUT_W'(1) << idx_inc;
                            wrap_n = &idx;
                        end else begin
                            cnt_n = cnt - 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                    out_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_q <= '0;
            ov_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            out_q <= out_n;
            ov_q  <= ov_n;
            armed <= 1'b1;
        end
    end

`ifdef DECODER_SCAN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            cnt    <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx    <= idx_n;
            cnt    <= cnt_n;
            wrap_q <= wrap_n;
        end
    end

    assign scan_wrap = wrap_q;
`else
    assign scan_wrap = 1'b0;
`endif

    assign out       = out_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_decoder_nbit_seq.sv
// tb_decoder_nbit_seq: self-checking bench for decoder_nbit_seq.
// Randomised direct traffic against a transaction-level model.
module tb_decoder_nbit_seq;

    localparam int IN_W    = 3;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 1 << IN_W;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic               out_valid;
    logic               scan_wrap;

    int checks;
    int bad;

    decoder_nbit_seq #(
        .IN_W(IN_W),
        .DWELL_W(DWELL_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode(mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in(sel),
        .dwell(dwell),
        .out(out),
        .out_valid(out_valid),
        .scan_wrap(scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] onehot(input int p);
        logic [OUT_W-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        en = 1'b1;
        mode = 1'b0;
        in_valid = 1'b0;
        sel = '0;
        dwell = '0;
        repeat (3) tick();
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: out=%h ov=%b rdy=%b want 0/0/0",
                     out, out_valid, in_ready);
        end
        checks++;
        if (scan_wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_wrap: got %b want 0", scan_wrap);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (in_ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%b want 1 within 2 cycles",
                     in_ready);
        end
    endtask

    task automatic test_direct_sweep(input logic m);
        en = 1'b0;
        tick();
        en = 1'b1;
        mode = m;
        for (int i = 0; i < OUT_W; i++) begin
            in_valid = 1'b1;
            sel = IN_W'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL sweep_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out !== onehot(i) || out_valid !== 1'b1
                || scan_wrap !== 1'b0) begin
                bad++;
                $display("FAIL sweep_out[%0d]: out=%b ov=%b wr=%b want %b/1/0",
                         i, out, out_valid, scan_wrap, onehot(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out !== onehot(OUT_W - 1) || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sweep_hold: out=%b ov=%b want %b/0",
                     out, out_valid, onehot(OUT_W - 1));
        end
    endtask

    // Transaction model: an accepted word shows up one cycle later as a
    // one-hot with a single-cycle valid; otherwise out holds; en low clears.
    task automatic test_random_direct(input int n);
        logic [OUT_W-1:0] exp_out;
        logic             exp_ready;
        logic             acc;
        int               acc_sel;
        en = 1'b0;
        in_valid = 1'b0;
        tick();
        exp_out = '0;
        for (int i = 0; i < n; i++) begin
            en = ($urandom_range(0, 9) != 0);
`ifdef DECODER_SCAN_EN
            mode = 1'b0;
`else
            mode = 1'($urandom_range(0, 1));
`endif
            in_valid = ($urandom_range(0, 9) < 7);
            sel = IN_W'($urandom_range(0, OUT_W - 1));
            #1;
            exp_ready = en;
            acc = en & in_valid;
            acc_sel = int'(sel);
            checks++;
            if (in_ready !== exp_ready) begin
                bad++;
                $display("FAIL rnd_ready[%0d]: got %b want %b",
                         i, in_ready, exp_ready);
            end
            tick();
            if (!en) exp_out = '0;
            else if (acc) exp_out = onehot(acc_sel);
            checks++;
            if (out !== exp_out || out_valid !== acc
                || scan_wrap !== 1'b0) begin
                bad++;
                $display("FAIL rnd_out[%0d]: out=%b ov=%b wr=%b want %b/%b/0",
                         i, out, out_valid, scan_wrap, exp_out, acc);
            end
        end
        in_valid = 1'b0;
        en = 1'b1;
        mode = 1'b0;
    endtask

    task automatic test_async_reset();
        bit seen;
        en = 1'b1;
        mode = 1'b0;
        in_valid = 1'b1;
        sel = 3'd6;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== onehot(6)) begin
            bad++;
            $display("FAIL arst_pre: out=%b want %b", out, onehot(6));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL arst_now: out=%b ov=%b rdy=%b want 0/0/0",
                     out, out_valid, in_ready);
        end
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (in_ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            bad++;
            $display("FAIL arst_ready: in_ready=%b want 1 within 2 cycles",
                     in_ready);
        end
    endtask

`ifdef DECODER_SCAN_EN
    // Position at cycle t since entry is floor(t/(d+1)) mod OUT_W.
    task automatic test_scan(input int d, input int n);
        int per;
        int wraps;
        int pos;
        logic exp_wrap;
        per = (d + 1) * OUT_W;
        wraps = 0;
        en = 1'b0;
        mode = 1'b1;
        tick();
        en = 1'b1;
        dwell = DWELL_W'(d);
        in_valid = 1'b1;
        sel = IN_W'($urandom_range(0, OUT_W - 1));
        checks++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL scan_ready_idle: got %b want 0", in_ready);
        end
        tick();
        for (int t = 0; t < n; t++) begin
            pos = (t / (d + 1)) % OUT_W;
            exp_wrap = (t > 0) && (t % per == 0);
            if (scan_wrap === 1'b1) wraps++;
            sel = IN_W'($urandom_range(0, OUT_W - 1));
            #1;
            checks++;
            if (out !== onehot(pos) || out_valid !== 1'b1
                || scan_wrap !== exp_wrap || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL scan_d%0d[%0d]: out=%b ov=%b wr=%b rdy=%b want %b/1/%b/0",
                         d, t, out, out_valid, scan_wrap, in_ready,
                         onehot(pos), exp_wrap);
            end
            tick();
        end
        checks++;
        if (wraps != (n - 1) / per) begin
            bad++;
            $display("FAIL scan_wraps_d%0d: got %0d want %0d",
                     d, wraps, (n - 1) / per);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_scan_disable();
        en = 1'b0;
        mode = 1'b1;
        dwell = '0;
        tick();
        en = 1'b1;
        repeat (6) tick();
        checks++;
        if (out !== onehot(5)) begin
            bad++;
            $display("FAIL mid_idx5: out=%b want %b", out, onehot(5));
        end
        en = 1'b0;
        tick();
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || scan_wrap !== 1'b0) begin
            bad++;
            $display("FAIL mid_off: out=%b ov=%b wr=%b want 0/0/0",
                     out, out_valid, scan_wrap);
        end
        en = 1'b1;
        tick();
        checks++;
        if (out !== onehot(0) || out_valid !== 1'b1 || scan_wrap !== 1'b0) begin
            bad++;
            $display("FAIL mid_restart: out=%b ov=%b wr=%b want %b/1/0",
                     out, out_valid, scan_wrap, onehot(0));
        end
        tick();
        checks++;
        if (out !== onehot(1)) begin
            bad++;
            $display("FAIL mid_next: out=%b want %b", out, onehot(1));
        end
    endtask

    task automatic test_mode_change();
        en = 1'b0;
        mode = 1'b0;
        dwell = 8'd1;
        tick();
        en = 1'b1;
        in_valid = 1'b1;
        sel = 3'd3;
        tick();
        checks++;
        if (out !== onehot(3) || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mc_direct: out=%b ov=%b want %b/1",
                     out, out_valid, onehot(3));
        end
        mode = 1'b1;
        sel = 3'd5;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mc_ready: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mc_gap1: out=%b ov=%b want 0/0", out, out_valid);
        end
        tick();
        checks++;
        if (out !== onehot(0) || out_valid !== 1'b1 || scan_wrap !== 1'b0) begin
            bad++;
            $display("FAIL mc_scan: out=%b ov=%b wr=%b want %b/1/0",
                     out, out_valid, scan_wrap, onehot(0));
        end
        mode = 1'b0;
        sel = 3'd2;
        tick();
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mc_gap2: out=%b ov=%b want 0/0", out, out_valid);
        end
        tick();
        checks++;
        if (out !== onehot(2) || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mc_back: out=%b ov=%b want %b/1",
                     out, out_valid, onehot(2));
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        bad = 0;
        test_reset();
        test_direct_sweep(1'b0);
`ifndef DECODER_SCAN_EN
        test_direct_sweep(1'b1);
`endif
        test_random_direct(300);
        test_async_reset();
`ifdef DECODER_SCAN_EN
        test_scan(2, 60);
        test_scan(0, 30);
        test_scan(int'($urandom_range(1, 4)), 90);
        test_mid_scan_disable();
        test_mode_change();
`endif
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
